// File: rtl/btb_update_scheduler.sv
// rtl/btb_update_scheduler.sv - two-requester in-order update FIFO feeding the BTB predictor write port
// Optional statistics counters are built when BTB_UPD_STATS_EN is defined.
module btb_update_scheduler #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             req0_valid,
   input  logic [PC_W-1:0]  req0_pc,
   input  logic [PC_W-1:0]  req0_target,
   input  logic             req0_taken,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [PC_W-1:0]  req1_pc,
   input  logic [PC_W-1:0]  req1_target,
   input  logic             req1_taken,
   output logic             req1_ready,
   input  logic             hold,
   input  logic             flush,
   output logic             wr_enable,
   output logic [PC_W-1:0]  update_pc,
   output logic [PC_W-1:0]  update_target_pc,
   output logic             is_taken,
   output logic [CNT_W-1:0] occupancy,
   output logic             full
`ifdef BTB_UPD_STATS_EN
   ,
   output logic [31:0]      stat_accepted,
   output logic [31:0]      stat_written,
   output logic [31:0]      stat_backpressure
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PC_W-1:0]  pc_q  [DEPTH];
   logic [PC_W-1:0]  tgt_q [DEPTH];
   logic             tk_q  [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] free;
   logic             empty, push0, push1, pop;
   logic [PTR_W-1:0] wr1_ptr;

   // Space is judged from registered occupancy only, so a same-cycle pop never frees a slot.
   assign free       = CNT_W'(DEPTH) - occ_q;
   assign empty      = (occ_q == '0);
   assign req0_ready = !flush && (free >= CNT_W'(1));
   assign req1_ready = !flush && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !req0_valid));
   assign push0      = req0_valid && req0_ready;
   assign push1      = req1_valid && req1_ready;
   assign wr_enable  = !empty && !hold && !flush;
   assign pop        = wr_enable;
   assign wr1_ptr    = wr_ptr_q + PTR_W'(push0);

   assign update_pc        = empty ? '0   : pc_q[rd_ptr_q];
   assign update_target_pc = empty ? '0   : tgt_q[rd_ptr_q];
   assign is_taken         = empty ? 1'b0 : tk_q[rd_ptr_q];
   assign occupancy        = occ_q;
   assign full             = (occ_q == CNT_W'(DEPTH));

   always_comb begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
      occ_d    = occ_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]  <= '0;
            tgt_q[i] <= '0;
            tk_q[i]  <= 1'b0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
         if (push0) begin
            pc_q[wr_ptr_q]  <= req0_pc;
            tgt_q[wr_ptr_q] <= req0_target;
            tk_q[wr_ptr_q]  <= req0_taken;
         end
         if (push1) begin
            pc_q[wr1_ptr]  <= req1_pc;
            tgt_q[wr1_ptr] <= req1_target;
            tk_q[wr1_ptr]  <= req1_taken;
         end
      end
   end

`ifdef BTB_UPD_STATS_EN
   logic [31:0] acc_q, acc_d, wrn_q, wrn_d, bp_q, bp_d;
   logic [32:0] acc_sum;
   logic        bp_evt;

   assign bp_evt  = !flush && ((req0_valid && !req0_ready) || (req1_valid && !req1_ready));
   assign acc_sum = {1'b0, acc_q} + 33'(push0) + 33'(push1);

   // Saturating counters; flush clears them alongside the FIFO.
   always_comb begin
      acc_d = acc_sum[32] ? '1 : acc_sum[31:0];
      wrn_d = (wr_enable && (wrn_q != '1)) ? wrn_q + 32'd1 : wrn_q;
      bp_d  = (bp_evt && (bp_q != '1)) ? bp_q + 32'd1 : bp_q;
      if (flush) begin
         acc_d = '0;
         wrn_d = '0;
         bp_d  = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         acc_q <= '0;
         wrn_q <= '0;
         bp_q  <= '0;
      end else begin
         acc_q <= acc_d;
         wrn_q <= wrn_d;
         bp_q  <= bp_d;
      end
   end

   assign stat_accepted     = acc_q;
   assign stat_written      = wrn_q;
   assign stat_backpressure = bp_q;
`endif

endmodule

// File: tb/tb_btb_update_scheduler.sv
// tb/tb_btb_update_scheduler.sv - directed self-checking bench for btb_update_scheduler
// Also checks the statistics outputs when BTB_UPD_STATS_EN is defined.
module tb_btb_update_scheduler;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        req0_valid, req0_taken, req1_valid, req1_taken;
   logic [31:0] req0_pc, req0_target, req1_pc, req1_target;
   logic        req0_ready, req1_ready, hold, flush;
   logic        wr_enable, is_taken, full;
   logic [31:0] update_pc, update_target_pc;
   logic [2:0]  occupancy;
`ifdef BTB_UPD_STATS_EN
   logic [31:0] stat_accepted, stat_written, stat_backpressure;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   btb_update_scheduler #(.DEPTH(4), .PC_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_target(req0_target),
      .req0_taken(req0_taken), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_target(req1_target),
      .req1_taken(req1_taken), .req1_ready(req1_ready),
      .hold(hold), .flush(flush),
      .wr_enable(wr_enable), .update_pc(update_pc), .update_target_pc(update_target_pc),
      .is_taken(is_taken), .occupancy(occupancy), .full(full)
`ifdef BTB_UPD_STATS_EN
      , .stat_accepted(stat_accepted), .stat_written(stat_written),
      .stat_backpressure(stat_backpressure)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      req0_valid = 0; req0_pc = 0; req0_target = 0; req0_taken = 0;
      req1_valid = 0; req1_pc = 0; req1_target = 0; req1_taken = 0;
   endtask

   task automatic push0(input logic [31:0] pc);
      req0_valid = 1; req0_pc = pc; req0_target = pc + 32'h1000; req0_taken = pc[0];
      tick();
      idle();
   endtask

   initial begin
      nRST = 0; hold = 0; flush = 0;
      idle();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_wr_enable", 32'(wr_enable), 0);
      chk("rst_occupancy", 32'(occupancy), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_update_pc", update_pc, 0);
      chk("rst_req0_ready", 32'(req0_ready), 1);
      nRST = 1;
      tick();

      // single update
      req0_valid = 1; req0_pc = 32'h100; req0_target = 32'h200; req0_taken = 1;
      #1;
      chk("s_req0_ready", 32'(req0_ready), 1);
      chk("s_wr_before", 32'(wr_enable), 0);
      tick();
      idle();
      #1;
      chk("s_wr_enable", 32'(wr_enable), 1);
      chk("s_update_pc", update_pc, 32'h100);
      chk("s_update_tgt", update_target_pc, 32'h200);
      chk("s_is_taken", 32'(is_taken), 1);
      chk("s_occ1", 32'(occupancy), 1);
      tick();
      chk("s_occ0", 32'(occupancy), 0);
      chk("s_wr_after", 32'(wr_enable), 0);
      chk("s_pc_empty", update_pc, 0);

      // dual push
      req0_valid = 1; req0_pc = 32'h10; req0_target = 32'h11; req0_taken = 0;
      req1_valid = 1; req1_pc = 32'h20; req1_target = 32'h21; req1_taken = 1;
      #1;
      chk("d_req0_ready", 32'(req0_ready), 1);
      chk("d_req1_ready", 32'(req1_ready), 1);
      tick();
      idle();
      chk("d_occ2", 32'(occupancy), 2);
      chk("d_wr0", 32'(wr_enable), 1);
      chk("d_pc0", update_pc, 32'h10);
      chk("d_taken0", 32'(is_taken), 0);
      tick();
      chk("d_wr1", 32'(wr_enable), 1);
      chk("d_pc1", update_pc, 32'h20);
      chk("d_tgt1", update_target_pc, 32'h21);
      chk("d_taken1", 32'(is_taken), 1);
      tick();
      chk("d_occ0", 32'(occupancy), 0);

      // fill under hold
      hold = 1;
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1; req0_pc = 32'h300 + 32'(i); req0_target = 32'h700 + 32'(i); req0_taken = 0;
         #1;
         chk("f_ready", 32'(req0_ready), 1);
         chk("f_wr_held", 32'(wr_enable), 0);
         tick();
      end
      req0_pc = 32'h304;
      #1;
      chk("f_full", 32'(full), 1);
      chk("f_occ4", 32'(occupancy), 4);
      chk("f_ready5", 32'(req0_ready), 0);
      chk("f_head_stable", update_pc, 32'h300);
      tick();
      idle();
      hold = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("f_wr", 32'(wr_enable), 1);
         chk("f_order", update_pc, 32'h300 + 32'(i));
         chk("f_tgt", update_target_pc, 32'h700 + 32'(i));
         tick();
      end
      chk("f_empty", 32'(occupancy), 0);

      // one free slot, fixed priority
      hold = 1;
      push0(32'h400); push0(32'h401); push0(32'h402);
      req0_valid = 1; req0_pc = 32'h410; req0_target = 32'h510;
      req1_valid = 1; req1_pc = 32'h420; req1_target = 32'h520;
      #1;
      chk("p_occ3", 32'(occupancy), 3);
      chk("p_req0_ready", 32'(req0_ready), 1);
      chk("p_req1_ready", 32'(req1_ready), 0);
      tick();
      req0_valid = 0;
      #1;
      chk("p_full", 32'(full), 1);
      chk("p_req1_wait", 32'(req1_ready), 0);
      hold = 0;
      #1;
      chk("p_req1_nopopspace", 32'(req1_ready), 0);
      chk("p_head400", update_pc, 32'h400);
      tick();
      chk("p_req1_ready", 32'(req1_ready), 1);
      chk("p_head401", update_pc, 32'h401);
      tick();
      req1_valid = 0;
      #1;
      chk("p_occ3b", 32'(occupancy), 3);
      chk("p_head402", update_pc, 32'h402);
      tick();
      chk("p_head410", update_pc, 32'h410);
      tick();
      chk("p_head420", update_pc, 32'h420);
      chk("p_tgt420", update_target_pc, 32'h520);
      tick();
      chk("p_empty", 32'(occupancy), 0);

      // flush
      hold = 1;
      push0(32'h500); push0(32'h501); push0(32'h502);
      hold = 0; flush = 1;
      req0_valid = 1; req0_pc = 32'h510;
      req1_valid = 1; req1_pc = 32'h520;
      #1;
      chk("x_occ3", 32'(occupancy), 3);
      chk("x_wr", 32'(wr_enable), 0);
      chk("x_req0_ready", 32'(req0_ready), 0);
      chk("x_req1_ready", 32'(req1_ready), 0);
      tick();
      flush = 0;
      idle();
      #1;
      chk("x_occ0", 32'(occupancy), 0);
      chk("x_wr_after", 32'(wr_enable), 0);
      chk("x_pc_after", update_pc, 0);
      tick();
      chk("x_wr_later", 32'(wr_enable), 0);

      // async reset mid-operation
      req0_valid = 1; req0_pc = 32'h600; req0_target = 32'h601; req0_taken = 1;
      req1_valid = 1; req1_pc = 32'h610; req1_target = 32'h611; req1_taken = 1;
      tick();
      idle();
      #1;
      chk("r_occ2", 32'(occupancy), 2);
      chk("r_wr1", 32'(wr_enable), 1);
      chk("r_taken1", 32'(is_taken), 1);
      #1;
      nRST = 0;
      #1;
      chk("r_wr0", 32'(wr_enable), 0);
      chk("r_occ0", 32'(occupancy), 0);
      chk("r_pc0", update_pc, 0);
      chk("r_tgt0", update_target_pc, 0);
      chk("r_taken0", 32'(is_taken), 0);
      chk("r_full0", 32'(full), 0);
`ifdef BTB_UPD_STATS_EN
      chk("r_stat_acc", stat_accepted, 0);
      chk("r_stat_wr", stat_written, 0);
      chk("r_stat_bp", stat_backpressure, 0);
`endif
      #3;
      nRST = 1;
      tick();
      chk("r_wr_after", 32'(wr_enable), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
